// File: rtl/param_commit_ctrl.sv
// Purpose: frames RX parameter bursts, length-checks and settles them, then commits on frame start or force.
// Latency: o_pkt_good SETTLE_CYC cycles after i_data_valid falls; o_param_ready 1 cycle after vsync/force.
// Backpressure: none; a new burst supersedes an uncommitted packet. Optional stats via PARAM_COMMIT_STATS_EN.
module param_commit_ctrl #(
  parameter int PKT_BYTES  = 12,
  parameter int SETTLE_CYC = 4,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_data_valid,
  input  logic             i_vsync,
  input  logic             i_force_commit,
  output logic             o_param_ready,
  output logic             o_pending,
  output logic             o_pkt_good,
  output logic             o_pkt_drop,
  output logic [CNT_W-1:0] o_commit_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // Settle counter only needs to reach SETTLE_CYC-1.
  localparam int               SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [LEN_W-1:0] LEN_PKT  = LEN_W'(PKT_BYTES);
  localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [SET_W-1:0] set_q, set_d;
  logic             pending_q, pending_d;
  logic             ready_q, ready_d;
  logic             good_q, good_d;
  logic             drop_q, drop_d;
  logic             commit_req;

  // A pending packet only exists in IDLE, so the commit window is IDLE with the RX line quiet.
  assign commit_req = pending_q & (i_vsync | i_force_commit) & ~i_data_valid;

  // Next-state and pulse decode for the receive FSM and commit handshake.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    set_d     = set_q;
    pending_d = pending_q;
    ready_d   = 1'b0;
    good_d    = 1'b0;
    drop_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_data_valid) begin
          // A fresh burst supersedes anything still waiting for a frame start.
          state_d   = RECV;
          len_d     = LEN_W'(1);
          pending_d = 1'b0;
        end else if (commit_req) begin
          ready_d   = 1'b1;
          pending_d = 1'b0;
        end
      end
      RECV: begin
        if (i_data_valid) begin
          if (len_q != LEN_MAX) len_d = len_q + LEN_W'(1);
        end else if (len_q == LEN_PKT) begin
          state_d = SETTLE;
          set_d   = '0;
        end else begin
          state_d = IDLE;
          drop_d  = 1'b1;
        end
      end
      SETTLE: begin
        if (i_data_valid) begin
          // Abandon the settling packet silently and start over.
          state_d = RECV;
          len_d   = LEN_W'(1);
        end else if (set_q == SET_LAST) begin
          state_d   = IDLE;
          pending_d = 1'b1;
          good_d    = 1'b1;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, length/settle counters and registered output pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      set_q     <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      good_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      set_q     <= set_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      good_q    <= good_d;
      drop_q    <= drop_d;
    end
  end

  assign o_param_ready = ready_q;
  assign o_pending     = pending_q;
  assign o_pkt_good    = good_q;
  assign o_pkt_drop    = drop_q;

`ifdef PARAM_COMMIT_STATS_EN
  logic [CNT_W-1:0] commit_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;

  // Wrapping statistics, updated on the same edge that raises the matching strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      commit_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      if (ready_d) commit_cnt_q <= commit_cnt_q + CNT_W'(1);
      if (drop_d)  drop_cnt_q   <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign o_commit_cnt = commit_cnt_q;
  assign o_drop_cnt   = drop_cnt_q;
`else
  assign o_commit_cnt = '0;
  assign o_drop_cnt   = '0;
`endif

endmodule
